// File: rtl/ipml_reg_fifo_downsizer_if.sv
// Handshake bundle for ipml_reg_fifo_downsizer: a wide producer side and a narrow consumer side.
// data_out_last exists only when IPML_DOWNSIZER_LAST_EN is defined.
interface ipml_reg_fifo_downsizer_if #(
    parameter int W_OUT = 8,
    parameter int RATIO = 4
);
    logic                     data_in_valid;
    logic [W_OUT*RATIO-1:0]   data_in;
    logic                     data_in_ready;
    logic                     data_out_ready;
    logic [W_OUT-1:0]         data_out;
    logic                     data_out_valid;
`ifdef IPML_DOWNSIZER_LAST_EN
    logic                     data_out_last;
`endif

    modport slave (
        input  data_in_valid,
        input  data_in,
        input  data_out_ready,
        output data_in_ready,
        output data_out,
        output data_out_valid
`ifdef IPML_DOWNSIZER_LAST_EN
        , output data_out_last
`endif
    );

    modport master (
        output data_in_valid,
        output data_in,
        output data_out_ready,
        input  data_in_ready,
        input  data_out,
        input  data_out_valid
`ifdef IPML_DOWNSIZER_LAST_EN
        , input  data_out_last
`endif
    );
endinterface

// File: rtl/ipml_reg_fifo_downsizer.sv
// Width downsizer: takes one W_OUT*RATIO word and emits RATIO W_OUT beats, LSB slice first.
// Optional word delimiter data_out_last is enabled by defining IPML_DOWNSIZER_LAST_EN.
module ipml_reg_fifo_downsizer #(
    parameter int W_OUT = 8,
    parameter int RATIO = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    ipml_reg_fifo_downsizer_if.slave       bus
);
    localparam int CW = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_BUSY  = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [W_OUT*RATIO-1:0]   hold_q, hold_d;
    logic                     full_s;
    logic                     last_beat_s;
    logic                     in_ready_s;
    logic                     in_fire_s;
    logic                     out_fire_s;
    logic [W_OUT-1:0]         beat_s;

    assign full_s      = (state_q == ST_BUSY);
    assign last_beat_s = (cnt_q == CNT_LAST);
    // Ready reaches back from the consumer so a new word can land on the last beat's edge.
    assign in_ready_s  = ~full_s | (bus.data_out_ready & last_beat_s);
    assign in_fire_s   = bus.data_in_valid & in_ready_s;
    assign out_fire_s  = full_s & bus.data_out_ready;

    // Select the current beat out of the holding register.
    always_comb begin
        beat_s = {W_OUT{1'b0}};
        for (int i = 0; i < RATIO; i++) begin
            if (cnt_q == CW'(i)) begin
                beat_s = hold_q[i*W_OUT +: W_OUT];
            end else begin
                beat_s = beat_s;
            end
        end
    end

    // Next-state logic for the EMPTY/BUSY machine, beat counter and holding register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire_s) begin
                    hold_d  = bus.data_in;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (out_fire_s && !last_beat_s) begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end else if (out_fire_s && in_fire_s) begin
                    hold_d = bus.data_in;
                    cnt_d  = {CW{1'b0}};
                end else if (out_fire_s) begin
                    // Explicit wrap so non-power-of-two ratios never reach RATIO.
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State, counter and holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            cnt_q   <= {CW{1'b0}};
            hold_q  <= {(W_OUT*RATIO){1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.data_in_ready  = in_ready_s;
    assign bus.data_out_valid = full_s;
    assign bus.data_out       = full_s ? beat_s : {W_OUT{1'b0}};
`ifdef IPML_DOWNSIZER_LAST_EN
    assign bus.data_out_last  = full_s & last_beat_s;
`endif

endmodule

// File: tb/tb_ipml_reg_fifo_downsizer.sv
// Directed bench for ipml_reg_fifo_downsizer: 8x4 instance for most scenarios, 4x3 for the odd ratio.
// Inputs change and outputs are sampled around the falling edge.
module tb_ipml_reg_fifo_downsizer;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    ipml_reg_fifo_downsizer_if #(.W_OUT(8), .RATIO(4)) ba ();
    ipml_reg_fifo_downsizer_if #(.W_OUT(4), .RATIO(3)) bb ();

    ipml_reg_fifo_downsizer #(.W_OUT(8), .RATIO(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
    ipml_reg_fifo_downsizer #(.W_OUT(4), .RATIO(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ba.data_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ba.data_out_valid); end
        checks++; if (ba.data_out !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", ba.data_out); end
        checks++; if (ba.data_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", ba.data_in_ready); end
        checks++; if (bb.data_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_b: got %b want 0", bb.data_out_valid); end
`ifdef IPML_DOWNSIZER_LAST_EN
        checks++; if (ba.data_out_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", ba.data_out_last); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [7:0] exp_b [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        @(negedge clk);
        ba.data_in_valid = 1'b1; ba.data_in = 32'hDDCC_BBAA; ba.data_out_ready = 1'b1;
        #1;
        checks++; if (ba.data_in_ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready: got %b want 1", ba.data_in_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ba.data_in_valid = 1'b0;
            #1;
            checks++; if (ba.data_out_valid !== 1'b1 || ba.data_out !== exp_b[k]) begin
                errors++; $display("FAIL single_beat%0d: got v=%b d=%h want v=1 d=%h", k, ba.data_out_valid, ba.data_out, exp_b[k]); end
            checks++; if (ba.data_in_ready !== (k == 3)) begin
                errors++; $display("FAIL single_in_ready%0d: got %b want %b", k, ba.data_in_ready, (k == 3)); end
`ifdef IPML_DOWNSIZER_LAST_EN
            checks++; if (ba.data_out_last !== (k == 3)) begin
                errors++; $display("FAIL single_last%0d: got %b want %b", k, ba.data_out_last, (k == 3)); end
`endif
        end
        @(negedge clk); #1;
        checks++; if (ba.data_out_valid !== 1'b0) begin errors++; $display("FAIL single_empty: got %b want 0", ba.data_out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        @(negedge clk);
        ba.data_in_valid = 1'b1; ba.data_in = 32'h0403_0201; ba.data_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ba.data_in_valid = (k < 4);
            ba.data_in = 32'h0807_0605;
            #1;
            checks++; if (ba.data_out_valid !== 1'b1 || ba.data_out !== exp_b[k]) begin
                errors++; $display("FAIL b2b_beat%0d: got v=%b d=%h want v=1 d=%h", k, ba.data_out_valid, ba.data_out, exp_b[k]); end
            checks++; if (ba.data_in_ready !== (k == 3 || k == 7)) begin
                errors++; $display("FAIL b2b_in_ready%0d: got %b want %b", k, ba.data_in_ready, (k == 3 || k == 7)); end
        end
        @(negedge clk); #1;
        checks++; if (ba.data_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", ba.data_out_valid); end
    endtask

    task automatic test_stall();
        logic       rdy   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] exp_b [7] = '{8'hAA, 8'hBB, 8'hBB, 8'hBB, 8'hCC, 8'hDD, 8'hDD};
        logic       exp_r [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        ba.data_in_valid = 1'b1; ba.data_in = 32'hDDCC_BBAA; ba.data_out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            ba.data_in_valid = 1'b0;
            ba.data_out_ready = rdy[k];
            #1;
            checks++; if (ba.data_out_valid !== 1'b1 || ba.data_out !== exp_b[k]) begin
                errors++; $display("FAIL stall_beat%0d: got v=%b d=%h want v=1 d=%h", k, ba.data_out_valid, ba.data_out, exp_b[k]); end
            checks++; if (ba.data_in_ready !== exp_r[k]) begin
                errors++; $display("FAIL stall_in_ready%0d: got %b want %b", k, ba.data_in_ready, exp_r[k]); end
        end
        @(negedge clk);
        ba.data_out_ready = 1'b1;
        #1;
        checks++; if (ba.data_out_valid !== 1'b0) begin errors++; $display("FAIL stall_empty: got %b want 0", ba.data_out_valid); end
    endtask

    task automatic test_ratio3();
        logic [3:0] exp_b [6] = '{4'hA, 4'hB, 4'hC, 4'h1, 4'h2, 4'h3};
        @(negedge clk);
        bb.data_in_valid = 1'b1; bb.data_in = 12'hCBA; bb.data_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bb.data_in_valid = 1'b0;
            #1;
            checks++; if (bb.data_out_valid !== 1'b1 || bb.data_out !== exp_b[k]) begin
                errors++; $display("FAIL r3_beat%0d: got v=%b d=%h want v=1 d=%h", k, bb.data_out_valid, bb.data_out, exp_b[k]); end
`ifdef IPML_DOWNSIZER_LAST_EN
            checks++; if (bb.data_out_last !== (k == 2)) begin
                errors++; $display("FAIL r3_last%0d: got %b want %b", k, bb.data_out_last, (k == 2)); end
`endif
        end
        @(negedge clk);
        bb.data_in_valid = 1'b1; bb.data_in = 12'h321;
        #1;
        checks++; if (bb.data_out_valid !== 1'b0 || bb.data_in_ready !== 1'b1) begin
            errors++; $display("FAIL r3_empty: got v=%b r=%b want v=0 r=1", bb.data_out_valid, bb.data_in_ready); end
        for (int k = 3; k < 6; k++) begin
            @(negedge clk);
            bb.data_in_valid = 1'b0;
            #1;
            checks++; if (bb.data_out_valid !== 1'b1 || bb.data_out !== exp_b[k]) begin
                errors++; $display("FAIL r3_wrap_beat%0d: got v=%b d=%h want v=1 d=%h", k, bb.data_out_valid, bb.data_out, exp_b[k]); end
        end
        @(negedge clk); #1;
        checks++; if (bb.data_out_valid !== 1'b0) begin errors++; $display("FAIL r3_final_empty: got %b want 0", bb.data_out_valid); end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] exp_b [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        @(negedge clk);
        ba.data_in_valid = 1'b1; ba.data_in = 32'hDDCC_BBAA; ba.data_out_ready = 1'b1;
        @(negedge clk);
        ba.data_in_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if (ba.data_out !== 8'hBB) begin errors++; $display("FAIL rmid_pre: got %h want bb", ba.data_out); end
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (ba.data_out_valid !== 1'b0 || ba.data_in_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_async: got v=%b r=%b want v=0 r=1", ba.data_out_valid, ba.data_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (ba.data_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_beat: got %b want 0", ba.data_out_valid); end
        ba.data_in_valid = 1'b1; ba.data_in = 32'h1122_3344;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ba.data_in_valid = 1'b0;
            #1;
            checks++; if (ba.data_out_valid !== 1'b1 || ba.data_out !== exp_b[k]) begin
                errors++; $display("FAIL rmid_beat%0d: got v=%b d=%h want v=1 d=%h", k, ba.data_out_valid, ba.data_out, exp_b[k]); end
        end
        @(negedge clk); #1;
    endtask

    task automatic test_hold_changing();
        logic [31:0] din   [4] = '{32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'h5566_7788};
        logic [7:0]  exp_b [8] = '{8'hA3, 8'hA2, 8'hA1, 8'hA0, 8'h88, 8'h77, 8'h66, 8'h55};
        @(negedge clk);
        ba.data_in_valid = 1'b1; ba.data_in = 32'hA0A1_A2A3; ba.data_out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ba.data_in_valid = (k < 4);
            ba.data_in = (k < 4) ? din[k] : 32'hFFFF_FFFF;
            #1;
            checks++; if (ba.data_out_valid !== 1'b1 || ba.data_out !== exp_b[k]) begin
                errors++; $display("FAIL hold_beat%0d: got v=%b d=%h want v=1 d=%h", k, ba.data_out_valid, ba.data_out, exp_b[k]); end
        end
        @(negedge clk);
        ba.data_in_valid = 1'b0;
        #1;
        checks++; if (ba.data_out_valid !== 1'b0) begin errors++; $display("FAIL hold_empty: got %b want 0", ba.data_out_valid); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        ba.data_in_valid = 1'b0; ba.data_in = 32'h0; ba.data_out_ready = 1'b0;
        bb.data_in_valid = 1'b0; bb.data_in = 12'h0; bb.data_out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_ratio3();
        test_reset_mid_word();
        test_hold_changing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
